// File: rtl/regfile_loader.sv
// rtl/regfile_loader.sv - byte-stream loader driving the register file write port
//
// Assembles bytes received over a valid/ready handshake into WIDTH-bit words
// (most-significant byte first). Each word is written to the register file at
// consecutive addresses START_ADDR..(1<<REGBITS)-1. A trailing XOR checksum
// byte is then compared against the XOR of all data bytes.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   start     single-cycle load request, ignored while busy
//   in_data   incoming byte
//   in_valid  in_data valid this cycle
//   in_ready  loader accepts a byte this cycle
//   regWrite  register file write enable
//   destAddr  register file write address
//   wrData    register file write data
//   busy      a load is in progress
//   done      one-cycle pulse when a load completes
//   error     checksum mismatch on the last load, sticky until next start
module regfile_loader #(
    parameter int WIDTH      = 16,
    parameter int REGBITS    = 4,
    parameter int START_ADDR = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               regWrite,
    output logic [REGBITS-1:0] destAddr,
    output logic [WIDTH-1:0]   wrData,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int BPW = WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [REGBITS-1:0] TOP_ADDR   = '1;
    localparam logic [REGBITS-1:0] FIRST_ADDR = REGBITS'(START_ADDR);
    localparam logic [CW-1:0]      LAST_BYTE  = CW'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [REGBITS-1:0] addr;
    logic [CW-1:0]      byteCnt;
    logic [7:0]         checksum;
    logic [WIDTH-1:0]   wordReg;
    logic [WIDTH-1:0]   nextWord;
    logic               accept;
    logic               lastByte;

    assign accept   = in_valid && in_ready;
    assign lastByte = (byteCnt == LAST_BYTE);
    // Shift the new byte in at the bottom; the oldest byte falls off the top.
    assign nextWord = WIDTH'({wordReg, in_data});

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RECV;
            RECV:    if (accept && lastByte) nextState = WRITE;
            WRITE:   nextState = (addr == TOP_ADDR) ? CHECK : RECV;
            CHECK:   if (accept) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b0;
            regWrite <= 1'b0;
            destAddr <= '0;
            wrData   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            addr     <= FIRST_ADDR;
            byteCnt  <= '0;
            checksum <= '0;
            wordReg  <= '0;
        end else begin
            in_ready <= (nextState == RECV) || (nextState == CHECK);
            regWrite <= (nextState == WRITE);
            busy     <= (nextState == RECV) || (nextState == WRITE) || (nextState == CHECK);
            done     <= (nextState == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        error    <= 1'b0;
                        addr     <= FIRST_ADDR;
                        byteCnt  <= '0;
                        checksum <= '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        wordReg  <= nextWord;
                        checksum <= checksum ^ in_data;
                        if (lastByte) begin
                            byteCnt  <= '0;
                            destAddr <= addr;
                            wrData   <= nextWord;
                        end else begin
                            byteCnt <= byteCnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (addr != TOP_ADDR) begin
                        addr <= addr + 1'b1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        error <= (in_data != checksum);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_loader.sv
// tb/tb_regfile_loader.sv - self-checking bench for regfile_loader
module tb_regfile_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  inData = 8'h00;
    logic        inValid = 1'b0;
    logic        sel = 1'b0;

    logic        rdy0, rw0, busy0, done0, err0;
    logic [3:0]  da0;
    logic [15:0] wd0;
    logic        rdy1, rw1, busy1, done1, err1;
    logic [1:0]  da1;
    logic [15:0] wd1;

    logic        rdy, rw, bsy, dn, er;
    logic [3:0]  da;
    logic [15:0] wd;

    always #5 clk = ~clk;

    regfile_loader dut (
        .clk(clk), .reset(reset), .start(start && !sel), .in_data(inData),
        .in_valid(inValid && !sel), .in_ready(rdy0), .regWrite(rw0),
        .destAddr(da0), .wrData(wd0), .busy(busy0), .done(done0), .error(err0)
    );

    regfile_loader #(.WIDTH(16), .REGBITS(2), .START_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .start(start && sel), .in_data(inData),
        .in_valid(inValid && sel), .in_ready(rdy1), .regWrite(rw1),
        .destAddr(da1), .wrData(wd1), .busy(busy1), .done(done1), .error(err1)
    );

    assign rdy = sel ? rdy1 : rdy0;
    assign rw  = sel ? rw1 : rw0;
    assign bsy = sel ? busy1 : busy0;
    assign dn  = sel ? done1 : done0;
    assign er  = sel ? err1 : err0;
    assign da  = sel ? {2'b00, da1} : da0;
    assign wd  = sel ? wd1 : wd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int firstAcc = -1;
    int doneCyc = 0;
    int writesSeen = 0;
    int donesSeen = 0;
    logic expErr = 1'b0;
    logic [3:0]  expAddr[$];
    logic [15:0] expData[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model compare: every write must be the next expected (address, word),
    // and every done pulse must carry the expected error flag.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (rw) begin
                check("ready_in_write", {31'd0, rdy}, 32'd0);
                if (expAddr.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    check("write_addr", {28'd0, da}, {28'd0, expAddr[0]});
                    check("write_data", {16'd0, wd}, {16'd0, expData[0]});
                    void'(expAddr.pop_front());
                    void'(expData.pop_front());
                end
                writesSeen++;
            end
            if (rdy && inValid && firstAcc < 0) firstAcc = cyc;
            if (dn) begin
                donesSeen++;
                doneCyc = cyc;
                check("busy_at_done", {31'd0, bsy}, 32'd0);
                check("error_at_done", {31'd0, er}, {31'd0, expErr});
                check("writes_left_at_done", expAddr.size(), 32'd0);
            end
        end
    end

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit ok = 0;
        inData  = b;
        inValid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic runLoad(input int nw, input int firstAddr, input logic [7:0] flip,
                           input bit gaps, input bit midStart, input int expCycles,
                           input logic [7:0] ckPin);
        logic [7:0]  ck = 8'h00;
        logic [15:0] w;
        int wBefore, dBefore;
        for (int i = 0; i < nw; i++) begin
            w = 16'h1001 + 16'(i);
            expAddr.push_back(4'(firstAddr + i));
            expData.push_back(w);
            ck = ck ^ w[15:8] ^ w[7:0];
        end
        check("checksum_pin", {24'd0, ck}, {24'd0, ckPin});
        wBefore  = writesSeen;
        dBefore  = donesSeen;
        firstAcc = -1;
        pulseStart();
        check("error_cleared_on_start", {31'd0, er}, 32'd0);
        expErr = (flip != 8'h00);
        for (int i = 0; i < nw; i++) begin
            w = 16'h1001 + 16'(i);
            for (int b = 0; b < 2; b++) begin
                if (gaps) begin
                    int g = $urandom_range(0, 3);
                    if (g > 0) begin
                        inValid = 1'b0;
                        repeat (g) begin
                            @(posedge clk); #1;
                        end
                    end
                end
                if (midStart && i == 5 && b == 0) start = 1'b1;
                sendByte(b == 0 ? w[15:8] : w[7:0]);
                start = 1'b0;
            end
        end
        sendByte(ck ^ flip);
        inValid = 1'b0;
        for (int k = 0; k < 100 && donesSeen == dBefore; k++) @(negedge clk);
        if (donesSeen == dBefore) check("done_timeout", 32'd0, 32'd1);
        check("write_count", writesSeen - wBefore, nw);
        check("done_count", donesSeen - dBefore, 32'd1);
        if (expCycles > 0) check("load_cycles", doneCyc - firstAcc + 1, expCycles);
        repeat (3) @(posedge clk);
        #1;
        check("error_sticky", {31'd0, er}, {31'd0, expErr});
        check("busy_after_done", {31'd0, bsy}, 32'd0);
    endtask

    initial begin
        int wBefore;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, rdy0}, 32'd0);
        check("rst_regWrite", {31'd0, rw0}, 32'd0);
        check("rst_destAddr", {28'd0, da0}, 32'd0);
        check("rst_wrData", {16'd0, wd0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_error", {31'd0, err0}, 32'd0);
        @(posedge clk); #1;

        // Nominal load: 15 words to r1..r15, 15*(2+1)+2 cycles.
        runLoad(15, 1, 8'h00, 0, 0, 47, 8'h10);
        // Corrupted checksum: writes still happen, error sticks.
        runLoad(15, 1, 8'h01, 0, 0, 47, 8'h10);
        // Random gaps between bytes; start clears the previous error.
        runLoad(15, 1, 8'h00, 1, 0, 0, 8'h10);
        // Start asserted mid-load is ignored.
        runLoad(15, 1, 8'h00, 0, 1, 47, 8'h10);

        // Reset after 3 words plus 1 byte.
        wBefore = writesSeen;
        for (int i = 0; i < 3; i++) begin
            expAddr.push_back(4'(1 + i));
            expData.push_back(16'h1001 + 16'(i));
        end
        pulseStart();
        for (int i = 0; i < 3; i++) begin
            sendByte(8'h10);
            sendByte(8'(i + 1));
        end
        sendByte(8'h10);
        inValid = 1'b0;
        reset   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_regWrite", {31'd0, rw0}, 32'd0);
        check("midrst_in_ready", {31'd0, rdy0}, 32'd0);
        check("midrst_writes", writesSeen - wBefore, 32'd3);
        check("midrst_pending", expAddr.size(), 32'd0);
        @(posedge clk); #1;
        runLoad(15, 1, 8'h00, 0, 0, 47, 8'h10);

        // REGBITS=2, START_ADDR=0 variant: 4 words to r0..r3.
        sel = 1'b1;
        @(posedge clk); #1;
        runLoad(4, 0, 8'h00, 0, 0, 14, 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule
